// File: rtl/vector_mem_unit_if.sv
// vector_mem_unit_if: request, memory and result signals of the vector load/store unit
interface vector_mem_unit_if #(
  parameter int LANES  = 16,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16
) ();
  logic                    start;
  logic [3:0]              opcode;
  logic [ADDR_W-1:0]       addr;
  logic [LANES*WORD_W-1:0] st_data;
  logic [WORD_W-1:0]       mem_rd_data;
  logic [ADDR_W-1:0]       mem_addr;
  logic [WORD_W-1:0]       mem_wr_data;
  logic                    mem_we;
  logic                    mem_re;
  logic [LANES*WORD_W-1:0] ld_data;
  logic                    busy;
  logic                    done;
  modport slave (
    input  start, opcode, addr, st_data, mem_rd_data,
    output mem_addr, mem_wr_data, mem_we, mem_re, ld_data, busy, done
  );
  modport master (
    output start, opcode, addr, st_data, mem_rd_data,
    input  mem_addr, mem_wr_data, mem_we, mem_re, ld_data, busy, done
  );
endinterface

// File: rtl/vector_mem_unit.sv
// vector_mem_unit: sequences a LANES-wide vector load/store into one word per cycle
module vector_mem_unit #(
  parameter int LANES  = 16,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  vector_mem_unit_if.slave  bus
);
  localparam int CW = LANES > 1 ? $clog2(LANES) : 1;
  localparam logic [3:0] OP_VLD = 4'b0100;
  localparam logic [3:0] OP_VST = 4'b0101;
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cap, nx;
  logic ld_q, pv, acc, last;
  logic [WORD_W-1:0] st_q  [LANES];
  logic [WORD_W-1:0] buf_q [LANES];
  assign acc  = state == IDLE && bus.start && (bus.opcode == OP_VLD || bus.opcode == OP_VST);
  assign last = cnt == CW'(LANES - 1);
  assign nx   = cnt + 1'b1;
  // next state: loads need one extra cycle to catch the final read word
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = acc ? XFER : IDLE;
      XFER:    state_d = last ? (ld_q ? DRAIN : DONE) : XFER;
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // state, lane counter and registered bus outputs; the strobe for lane k is set up one edge early
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      cap             <= '0;
      ld_q            <= 1'b0;
      pv              <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_re      <= 1'b0;
      bus.ld_data     <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      state      <= state_d;
      pv         <= bus.mem_re;
      cap        <= cnt;
      bus.busy   <= state_d != IDLE;
      bus.done   <= state_d == DONE;
      bus.mem_we <= 1'b0;
      bus.mem_re <= 1'b0;
      if (acc) begin
        ld_q         <= bus.opcode == OP_VLD;
        cnt          <= '0;
        bus.mem_addr <= bus.addr;
        bus.mem_we   <= bus.opcode == OP_VST;
        bus.mem_re   <= bus.opcode == OP_VLD;
        if (bus.opcode == OP_VST) bus.mem_wr_data <= bus.st_data[WORD_W-1:0];
      end
      if (state == XFER && !last) begin
        cnt          <= nx;
        bus.mem_addr <= bus.mem_addr + 1'b1;
        bus.mem_we   <= !ld_q;
        bus.mem_re   <= ld_q;
        if (!ld_q) bus.mem_wr_data <= st_q[nx];
      end
      if (state == DRAIN)
        for (int i = 0; i < LANES; i++)
          bus.ld_data[i*WORD_W +: WORD_W] <= i == LANES - 1 ? bus.mem_rd_data : buf_q[i];
    end
  end
  // store vector snapshot taken at acceptance so later input changes cannot leak in
  always_ff @(posedge clk) begin
    if (acc)
      for (int i = 0; i < LANES; i++)
        st_q[i] <= bus.st_data[i*WORD_W +: WORD_W];
  end
  // load buffer: each read word lands one cycle after its strobe, tagged with the issuing lane
  always_ff @(posedge clk) begin
    if (pv) buf_q[cap] <= bus.mem_rd_data;
  end
endmodule
